dll_lock_seq: RTL and testbench

- Lock sequencer for the FMDLL. Drives the harmonic-lock detector's select/arm input and the phase-detector/delay-line reset.
- Gates the charge pump, watches the detector's active-low Reset_PD output for harmonic-lock events, and declares lock after enough clean observation windows.
- Retries initialisation on harmonic lock and flags failure after a bounded number of retries.
- Sits beside the harmonic-lock detector in the DLL top level, clocked by the reference clock.

---
 rtl/dll_seq_pkg.sv | 49 ++++
 rtl/hld_evt_filter.sv | 29 ++
 rtl/dll_lock_seq.sv | 129 ++++++++++++
 tb/tb_dll_lock_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_seq_pkg.sv
// rtl/dll_seq_pkg.sv - shared state encoding, defaults and output decode for the DLL lock sequencer
package dll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    TRACK  = 3'd2,
    LOCKED = 3'd3,
    RETRY  = 3'd4,
    FAIL   = 3'd5
  } state_t;

  localparam int SETTLE_CYC_DEF = 32;
  localparam int WIN_CYC_DEF    = 128;
  localparam int LOCK_WIN_DEF   = 4;
  localparam int MAX_RETRY_DEF  = 7;
  localparam int CNT_W_DEF      = 8;

  typedef struct packed {
    logic sel;
    logic pd_rst;
    logic cp_en;
    logic locked;
    logic fail;
  } ctl_t;

  // Every state not listed keeps the delay line in reset with the pump off.
  function automatic ctl_t state_ctl(input state_t st);
    ctl_t c;
    c = '{sel: 1'b0, pd_rst: 1'b1, cp_en: 1'b0, locked: 1'b0, fail: 1'b0};
    case (st)
      TRACK: begin
        c.sel    = 1'b1;
        c.pd_rst = 1'b0;
        c.cp_en  = 1'b1;
      end
      LOCKED: begin
        c.sel    = 1'b1;
        c.pd_rst = 1'b0;
        c.cp_en  = 1'b1;
        c.locked = 1'b1;
      end
      FAIL: c.fail = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hld_evt_filter.sv
// rtl/hld_evt_filter.sv - synchroniser and two-sample low filter for the detector's Reset_PD output
module hld_evt_filter (
  input  logic clk_ext,
  input  logic rst,
  input  logic clr,
  input  logic reset_pd,
  output logic hld_evt
);

  logic sync1;
  logic sync2;
  logic samp;

  // All flops idle at 1 ("no event"); clr flushes any stale low level.
  always_ff @(posedge clk_ext) begin
    if (rst || clr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      samp  <= 1'b1;
    end else begin
      sync1 <= reset_pd;
      sync2 <= sync1;
      samp  <= sync2;
    end
  end

  assign hld_evt = ~sync2 & ~samp;

endmodule

// File: rtl/dll_lock_seq.sv
// rtl/dll_lock_seq.sv - FMDLL lock sequencer: settle, observe windows, retry on harmonic lock, flag failure
module dll_lock_seq
  import dll_seq_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WIN_CYC    = WIN_CYC_DEF,
  parameter int LOCK_WIN   = LOCK_WIN_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       start,
  input  logic       reset_pd,
  output logic       sel,
  output logic       pd_rst,
  output logic       cp_en,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  localparam int                 CLEAN_W     = $clog2(LOCK_WIN + 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   WIN_LAST    = CNT_W'(WIN_CYC - 1);
  localparam logic [CLEAN_W-1:0] LOCK_LAST   = CLEAN_W'(LOCK_WIN - 1);
  localparam logic [2:0]         RETRY_MAX   = 3'(MAX_RETRY);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CLEAN_W-1:0] clean_q, clean_d;
  logic [2:0]         retry_q, retry_d;
  ctl_t               ctl_q;
  logic               clr;
  logic               hld_evt;

  hld_evt_filter u_filter (
    .clk_ext  (clk_ext),
    .rst      (rst),
    .clr      (clr),
    .reset_pd (reset_pd),
    .hld_evt  (hld_evt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    retry_d = retry_q;
    clr     = 1'b0;
    if (!start) begin
      state_d = IDLE;
      cnt_d   = '0;
      clean_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = INIT;
          cnt_d   = '0;
        end
        INIT: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = TRACK;
            cnt_d   = '0;
            clean_d = '0;
            clr     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // An event on the window's last cycle still wins over the clean count.
        TRACK: begin
          if (hld_evt) begin
            state_d = RETRY;
            cnt_d   = '0;
          end else if (cnt_q == WIN_LAST) begin
            cnt_d   = '0;
            clean_d = clean_q + 1'b1;
            if (clean_q == LOCK_LAST) state_d = LOCKED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (hld_evt) state_d = RETRY;
        end
        RETRY: begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = FAIL;
          end else begin
            state_d = INIT;
            retry_d = retry_q + 1'b1;
          end
        end
        FAIL: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clean_q <= '0;
      retry_q <= '0;
      ctl_q   <= state_ctl(IDLE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      retry_q <= retry_d;
      ctl_q   <= state_ctl(state_d);
    end
  end

  assign sel       = ctl_q.sel;
  assign pd_rst    = ctl_q.pd_rst;
  assign cp_en     = ctl_q.cp_en;
  assign locked    = ctl_q.locked;
  assign fail      = ctl_q.fail;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_dll_lock_seq.sv
// tb/tb_dll_lock_seq.sv - scoreboard bench for dll_lock_seq: expected state transitions queued with cycle windows
module tb_dll_lock_seq;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_TRACK  = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_RETRY  = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic       clk_ext  = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       reset_pd = 1'b1;
  logic       sel, pd_rst, cp_en, locked, fail;
  logic [2:0] retry_cnt, state;

  typedef struct {
    logic [2:0] st;
    logic [2:0] rc;
    int         lo;
    int         hi;
  } tr_t;

  tr_t        exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [2:0] prev_state = 3'd0;

  dll_lock_seq dut (
    .clk_ext   (clk_ext),
    .rst       (rst),
    .start     (start),
    .reset_pd  (reset_pd),
    .sel       (sel),
    .pd_rst    (pd_rst),
    .cp_en     (cp_en),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  always #5 clk_ext = ~clk_ext;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached with %0d failures so far, required completion", n_fail);
    $fatal(1, "watchdog expired");
  end

  // {sel, pd_rst, cp_en, locked, fail} required in each state
  function automatic logic [4:0] exp_out(input logic [2:0] st);
    case (st)
      S_TRACK:  return 5'b10100;
      S_LOCKED: return 5'b10110;
      S_FAIL:   return 5'b01001;
      default:  return 5'b01000;
    endcase
  endfunction

  task automatic expect_tr(input logic [2:0] st, input logic [2:0] rc, input int lo, input int hi);
    exp_q.push_back('{st: st, rc: rc, lo: lo, hi: hi});
  endtask

  // Advance n cycles; every observed state change is popped against the scoreboard.
  task automatic advance(input int n);
    tr_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_ext);
      cyc++;
      if (state !== prev_state) begin
        prev_state = state;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: state=%0d retry_cnt=%0d at cycle %0d, required no transition", state, retry_cnt, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({state, retry_cnt, sel, pd_rst, cp_en, locked, fail} !== {e.st, e.rc, exp_out(e.st)}) begin
            n_fail++;
            $display("FAIL sb_value: got state=%0d rc=%0d outs=%b, required state=%0d rc=%0d outs=%b",
                     state, retry_cnt, {sel, pd_rst, cp_en, locked, fail}, e.st, e.rc, exp_out(e.st));
          end
          n_chk++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_fail++;
            $display("FAIL sb_timing: state=%0d entered at cycle %0d, required %0d..%0d", state, cyc, e.lo, e.hi);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    reset_pd = 1'b1;
    advance(3);
    n_chk++;
    if ({state, sel, pd_rst, cp_en, locked, fail, retry_cnt} !== {S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %b, required %b", {state, sel, pd_rst, cp_en, locked, fail, retry_cnt},
               {S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    end
    rst = 1'b0;
    advance(2);
  endtask

  task automatic test_clean_lock();
    int c;
    c = cyc;
    start = 1'b1;
    expect_tr(S_INIT, 3'd0, c + 1, c + 1);
    expect_tr(S_TRACK, 3'd0, c + 33, c + 33);
    expect_tr(S_LOCKED, 3'd0, c + 544, c + 546);
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) advance(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clean_drain: %0d transitions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    advance(10);
    n_chk++;
    if ({locked, retry_cnt} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL clean_hold: got locked=%b retry_cnt=%0d, required 1 and 0", locked, retry_cnt);
    end
    start = 1'b0;
    expect_tr(S_IDLE, 3'd0, cyc + 1, cyc + 1);
    advance(2);
  endtask

  task automatic test_glitch();
    int c;
    c = cyc;
    start = 1'b1;
    expect_tr(S_INIT, 3'd0, c + 1, c + 1);
    expect_tr(S_TRACK, 3'd0, c + 33, c + 33);
    expect_tr(S_LOCKED, 3'd0, c + 544, c + 546);
    advance(100);
    reset_pd = 1'b0;
    advance(1);
    reset_pd = 1'b1;
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) advance(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_drain: %0d transitions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    start = 1'b0;
    expect_tr(S_IDLE, 3'd0, cyc + 1, cyc + 1);
    advance(2);
  endtask

  task automatic test_single_event();
    int c;
    c = cyc;
    start = 1'b1;
    expect_tr(S_INIT, 3'd0, c + 1, c + 1);
    expect_tr(S_TRACK, 3'd0, c + 33, c + 33);
    advance(200);
    reset_pd = 1'b0;
    expect_tr(S_RETRY, 3'd0, c + 204, c + 205);
    expect_tr(S_INIT, 3'd1, c + 205, c + 206);
    expect_tr(S_TRACK, 3'd1, c + 237, c + 238);
    expect_tr(S_LOCKED, 3'd1, c + 748, c + 750);
    advance(3);
    reset_pd = 1'b1;
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) advance(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL event_drain: %0d transitions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    advance(3);
    n_chk++;
    if ({locked, retry_cnt} !== {1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL event_relock: got locked=%b retry_cnt=%0d, required 1 and 1", locked, retry_cnt);
    end
    start = 1'b0;
    expect_tr(S_IDLE, 3'd0, cyc + 1, cyc + 1);
    advance(2);
  endtask

  task automatic test_loss_of_lock();
    int c;
    c = cyc;
    start = 1'b1;
    expect_tr(S_INIT, 3'd0, c + 1, c + 1);
    expect_tr(S_TRACK, 3'd0, c + 33, c + 33);
    expect_tr(S_LOCKED, 3'd0, c + 544, c + 546);
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) advance(1);
    advance(20);
    c = cyc;
    reset_pd = 1'b0;
    expect_tr(S_RETRY, 3'd0, c + 4, c + 5);
    expect_tr(S_INIT, 3'd1, c + 5, c + 6);
    advance(3);
    reset_pd = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) advance(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lol_drain: %0d transitions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    n_chk++;
    if ({pd_rst, locked, retry_cnt} !== {1'b1, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL lol_outputs: got pd_rst=%b locked=%b retry_cnt=%0d, required 1 0 1", pd_rst, locked, retry_cnt);
    end
    start = 1'b0;
    expect_tr(S_IDLE, 3'd0, cyc + 1, cyc + 1);
    advance(2);
  endtask

  task automatic test_exhausted();
    int c;
    c = cyc;
    reset_pd = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      expect_tr(S_INIT, 3'(k), c + 1 + 37 * k, c + 1 + 37 * k + k);
      expect_tr(S_TRACK, 3'(k), c + 33 + 37 * k, c + 33 + 37 * k + k);
      expect_tr(S_RETRY, 3'(k), c + 37 + 37 * k, c + 38 + 37 * k + k);
    end
    expect_tr(S_FAIL, 3'd7, c + 297, c + 305);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) advance(1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exhaust_drain: %0d transitions pending, required 0", exp_q.size());
      exp_q.delete();
    end
    advance(5);
    n_chk++;
    if ({fail, retry_cnt, cp_en} !== {1'b1, 3'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL exhaust_sticky: got fail=%b retry_cnt=%0d cp_en=%b, required 1 7 0", fail, retry_cnt, cp_en);
    end
    start = 1'b0;
    expect_tr(S_IDLE, 3'd0, cyc + 1, cyc + 1);
    advance(1);
    n_chk++;
    if ({state, fail} !== {S_IDLE, 1'b0}) begin
      n_fail++;
      $display("FAIL exhaust_release: got state=%0d fail=%b, required 0 and 0", state, fail);
    end
    reset_pd = 1'b1;
    advance(2);
  endtask

  task automatic test_abort();
    int c;
    c = cyc;
    start = 1'b1;
    expect_tr(S_INIT, 3'd0, c + 1, c + 1);
    expect_tr(S_TRACK, 3'd0, c + 33, c + 33);
    advance(40);
    rst = 1'b1;
    expect_tr(S_IDLE, 3'd0, cyc + 1, cyc + 1);
    advance(1);
    n_chk++;
    if ({state, sel, pd_rst, cp_en, locked, fail, retry_cnt} !== {S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL abort_rst: got %b, required %b", {state, sel, pd_rst, cp_en, locked, fail, retry_cnt},
               {S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    end
    advance(2);
    rst = 1'b0;
    start = 1'b0;
    advance(2);
    c = cyc;
    start = 1'b1;
    expect_tr(S_INIT, 3'd0, c + 1, c + 1);
    advance(10);
    start = 1'b0;
    expect_tr(S_IDLE, 3'd0, cyc + 1, cyc + 1);
    advance(1);
    n_chk++;
    if ({state, pd_rst, sel} !== {S_IDLE, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_start: got state=%0d pd_rst=%b sel=%b, required 0 1 0", state, pd_rst, sel);
    end
    advance(2);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_drain: %0d transitions pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_glitch();
    test_single_event();
    test_loss_of_lock();
    test_exhausted();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
